ctrl_pkt_loader: RTL and testbench

Upstream feeder for `control_plane`. It accepts a configuration packet on a 512-bit AXI-Stream slave and parses the header phit. It buffers the complete body, then replays it to `control_plane` as a back-to-back `wr_data` burst after a `start_loader` pulse. Once the load completes, it raises `start_stream_in` and holds it until `control_plane` reports `ready_stream_in`.

---
 rtl/ctrl_pkt_pkg.sv | 23 ++
 rtl/ctrl_phit_fifo.sv | 51 +++++
 rtl/ctrl_pkt_loader.sv | 207 ++++++++++++++++++++
 tb/tb_ctrl_pkt_loader.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkt_pkg.sv
// Shared definitions for the control-plane packet loader: header layout,
// opcode, table count and FSM state encoding.
package ctrl_pkt_pkg;

  localparam logic [7:0] CFG_OPCODE  = 8'hC0;
  localparam int         HDR_FIELD_W = 8;
  localparam int         HDR_OPC_LSB = 504;
  localparam int         HDR_CFG_LSB = 0;
  localparam int         HDR_INB_LSB = 16;
  localparam int         NUM_TABLES  = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_DISCARD,
    ST_DISCARD_OK,
    ST_LAUNCH,
    ST_GAP,
    ST_DRAIN,
    ST_DONE
  } ctrl_ld_state_t;

endpackage

// File: rtl/ctrl_phit_fifo.sv
// Synchronous phit FIFO with registered read data; only the pointers are reset,
// storage and read register are plain datapath flops.
module ctrl_phit_fifo
  import ctrl_pkt_pkg::*;
#(
  parameter int DATA_W = 512,
  parameter int DEPTH  = 64
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  input  logic              flush,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wptr_q, rptr_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic              do_push, do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
    if (do_pop)  rdata_q <= mem_q[rptr_q[AW-1:0]];
  end

endmodule

// File: rtl/ctrl_pkt_loader.sv
// Receives a configuration packet over AXI-Stream, buffers the body and replays
// it to control_plane as a contiguous wr_data burst, then requests the stream phase.
module ctrl_pkt_loader
  import ctrl_pkt_pkg::*;
#(
  parameter int phit_size    = 512,
  parameter int dwidth_RFadd = 8,
  parameter int FIFO_DEPTH   = 64,
  parameter int LOAD_GAP     = 2
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [phit_size-1:0]    s_tdata,
  input  logic                    s_tvalid,
  input  logic                    s_tlast,
  output logic                    s_tready,
  output logic                    start_loader,
  output logic [phit_size-1:0]    wr_data,
  output logic [dwidth_RFadd-1:0] num_entry_config_table,
  output logic [dwidth_RFadd-1:0] num_entry_inbound,
  output logic                    start_stream_in,
  input  logic                    ready_stream_in,
  output logic                    busy,
  output logic                    err
);

  localparam int TW = dwidth_RFadd + 4;
  localparam int GW = (LOAD_GAP > 1) ? $clog2(LOAD_GAP) : 1;

  ctrl_ld_state_t          state_q, state_d;
  logic [TW-1:0]           total_q, total_d;
  logic [TW-1:0]           cnt_q, cnt_d;
  logic [GW-1:0]           gap_q, gap_d;
  logic [dwidth_RFadd-1:0] cfg_q, cfg_d;
  logic [dwidth_RFadd-1:0] inb_q, inb_d;
  logic                    err_q, err_d;
  logic                    vld_q;
  logic                    active_q;

  logic                    tready_raw, beat;
  logic                    push, pop_req, pop, flush;
  logic                    launch_c, ssi_c;
  logic                    fifo_full, fifo_empty;
  logic [phit_size-1:0]    fifo_rdata;

  logic [dwidth_RFadd-1:0] hdr_cfg, hdr_inb;
  logic [7:0]              hdr_opc;
  logic [TW-1:0]           hdr_total;
  logic                    hdr_ok;

  assign hdr_opc   = s_tdata[HDR_OPC_LSB +: HDR_FIELD_W];
  assign hdr_cfg   = s_tdata[HDR_CFG_LSB +: dwidth_RFadd];
  assign hdr_inb   = s_tdata[HDR_INB_LSB +: dwidth_RFadd];
  assign hdr_total = TW'(NUM_TABLES) * TW'(hdr_cfg) + TW'(hdr_inb);
  assign hdr_ok    = (hdr_opc == CFG_OPCODE) && (hdr_total != '0) &&
                     (32'(hdr_total) <= 32'(FIFO_DEPTH)) && !s_tlast;

  // s_tready is held low until the first clock after reset release.
  always_comb begin
    tready_raw = 1'b0;
    case (state_q)
      ST_IDLE, ST_DISCARD, ST_DISCARD_OK: tready_raw = 1'b1;
      ST_FILL:                            tready_raw = !fifo_full;
      default:                            tready_raw = 1'b0;
    endcase
  end

  assign s_tready = active_q && tready_raw;
  assign beat     = s_tvalid && s_tready;
  assign pop      = pop_req && !fifo_empty;

  always_comb begin
    state_d  = state_q;
    total_d  = total_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    cfg_d    = cfg_q;
    inb_d    = inb_q;
    err_d    = 1'b0;
    push     = 1'b0;
    pop_req  = 1'b0;
    flush    = 1'b0;
    launch_c = 1'b0;
    ssi_c    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (beat) begin
          if (hdr_ok) begin
            cfg_d   = hdr_cfg;
            inb_d   = hdr_inb;
            total_d = hdr_total;
            state_d = ST_FILL;
          end else begin
            err_d = 1'b1;
            if (!s_tlast) state_d = ST_DISCARD;
          end
        end
      end
      ST_FILL: begin
        if (beat) begin
          push  = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == total_q - 1'b1) begin
            if (s_tlast) begin
              state_d = ST_LAUNCH;
            end else begin
              err_d   = 1'b1;
              state_d = ST_DISCARD_OK;
            end
          end else if (s_tlast) begin
            err_d   = 1'b1;
            flush   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_DISCARD: begin
        if (beat && s_tlast) state_d = ST_IDLE;
      end
      ST_DISCARD_OK: begin
        if (beat && s_tlast) state_d = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        launch_c = 1'b1;
        gap_d    = '0;
        cnt_d    = '0;
        if (LOAD_GAP == 0) begin
          pop_req = 1'b1;
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        // First pop issues in the last gap cycle so phit 0 lands on the first DRAIN cycle.
        gap_d = gap_q + 1'b1;
        if (int'(gap_q) == LOAD_GAP - 1) begin
          pop_req = 1'b1;
          cnt_d   = '0;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == total_q - 1'b1) begin
          state_d = ST_DONE;
        end else begin
          pop_req = 1'b1;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        ssi_c = 1'b1;
        if (ready_stream_in) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      total_q  <= '0;
      cnt_q    <= '0;
      gap_q    <= '0;
      cfg_q    <= '0;
      inb_q    <= '0;
      err_q    <= 1'b0;
      vld_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      total_q  <= total_d;
      cnt_q    <= cnt_d;
      gap_q    <= gap_d;
      cfg_q    <= cfg_d;
      inb_q    <= inb_d;
      err_q    <= err_d;
      vld_q    <= pop;
      active_q <= 1'b1;
    end
  end

  ctrl_phit_fifo #(
    .DATA_W (phit_size),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (s_tdata),
    .pop   (pop),
    .flush (flush),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign wr_data                = vld_q ? fifo_rdata : '0;
  assign start_loader           = launch_c;
  assign start_stream_in        = ssi_c;
  assign busy                   = (state_q != ST_IDLE);
  assign err                    = err_q;
  assign num_entry_config_table = cfg_q;
  assign num_entry_inbound      = inb_q;

endmodule

// File: tb/tb_ctrl_pkt_loader.sv
// Scoreboard bench for ctrl_pkt_loader: directed packets push expected events,
// a negedge monitor pops and compares them in order with inter-event cycle spacing.
module tb_ctrl_pkt_loader;

  localparam int PW = 512;
  localparam int RW = 8;

  logic          clk;
  logic          rst;
  logic [PW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tlast;
  logic          s_tready;
  logic          start_loader;
  logic [PW-1:0] wr_data;
  logic [RW-1:0] num_entry_config_table;
  logic [RW-1:0] num_entry_inbound;
  logic          start_stream_in;
  logic          ready_stream_in;
  logic          busy;
  logic          err;

  ctrl_pkt_loader dut (
    .clk                    (clk),
    .rst                    (rst),
    .s_tdata                (s_tdata),
    .s_tvalid               (s_tvalid),
    .s_tlast                (s_tlast),
    .s_tready               (s_tready),
    .start_loader           (start_loader),
    .wr_data                (wr_data),
    .num_entry_config_table (num_entry_config_table),
    .num_entry_inbound      (num_entry_inbound),
    .start_stream_in        (start_stream_in),
    .ready_stream_in        (ready_stream_in),
    .busy                   (busy),
    .err                    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {EV_TL, EV_ERR, EV_SL, EV_WR, EV_SSI, EV_SSF, EV_BF} ev_t;
  typedef struct {
    ev_t kind;
    int  val;
    int  dly;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   last_cyc = 0;
  logic mon_en = 1'b0;
  logic prev_busy = 1'b0;
  logic prev_ssi = 1'b0;

  function automatic void expect_ev(ev_t k, int v, int d);
    exp_t e;
    e.kind = k;
    e.val  = v;
    e.dly  = d;
    sb.push_back(e);
  endfunction

  function automatic void observe(ev_t k, logic [PW-1:0] act);
    exp_t e;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL unexpected_%s at cycle %0d: got value %0h, required no event", k.name(), cyc, act);
    end else begin
      e = sb.pop_front();
      if (e.kind != k || act != PW'(e.val)) begin
        fails++;
        $display("FAIL event_order at cycle %0d: got %s value %0h, required %s value %0h",
                 cyc, k.name(), act, e.kind.name(), e.val);
      end else if (e.dly >= 0 && (cyc - last_cyc) != e.dly) begin
        fails++;
        $display("FAIL event_timing %s value %0h: got spacing %0d cycles, required %0d",
                 k.name(), act, cyc - last_cyc, e.dly);
      end
    end
    last_cyc = cyc;
  endfunction

  function automatic void chk(string nm, logic [PW-1:0] act, logic [PW-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endfunction

  // Monitor: runs mid-cycle, in a fixed per-cycle event order.
  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      if (s_tvalid && s_tready && s_tlast) observe(EV_TL, '0);
      if (err)                             observe(EV_ERR, '0);
      if (start_loader)                    observe(EV_SL, '0);
      if (wr_data != '0)                   observe(EV_WR, wr_data);
      if (start_stream_in && !prev_ssi)    observe(EV_SSI, '0);
      if (!start_stream_in && prev_ssi)    observe(EV_SSF, '0);
      if (!busy && prev_busy)              observe(EV_BF, '0);
    end
    prev_busy = busy;
    prev_ssi  = start_stream_in;
  end

  function automatic logic [PW-1:0] hdr(logic [7:0] op, logic [7:0] cfg, logic [7:0] inb);
    logic [PW-1:0] h;
    h          = '0;
    h[511:504] = op;
    h[7:0]     = cfg;
    h[23:16]   = inb;
    return h;
  endfunction

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [PW-1:0] d, input logic last);
    int n;
    n        = 0;
    s_tdata  = d;
    s_tvalid = 1'b1;
    s_tlast  = last;
    forever begin
      @(negedge clk);
      if (s_tready) break;
      n++;
      if (n > 200) begin
        tests++;
        fails++;
        $display("FAIL send_timeout: got s_tready=0 for %0d cycles, required 1", n);
        break;
      end
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] op, input logic [7:0] cfg, input logic [7:0] inb,
                          input int nbody, input bit gapped);
    send_beat(hdr(op, cfg, inb), nbody == 0);
    for (int k = 1; k <= nbody; k++) begin
      if (gapped) idle_cycle();
      send_beat(PW'(k), k == nbody);
    end
  endtask

  // Expected launch: start_loader one cycle after the last beat, burst after LOAD_GAP+1.
  task automatic expect_load(input int n, input bit ready_hi);
    expect_ev(EV_SL, 0, 1);
    expect_ev(EV_WR, 1, 3);
    for (int k = 2; k <= n; k++) expect_ev(EV_WR, k, 1);
    expect_ev(EV_SSI, 0, 1);
    expect_ev(EV_SSF, 0, ready_hi ? 1 : 5);
    expect_ev(EV_BF, 0, 0);
  endtask

  task automatic wait_sb();
    int n;
    n = 0;
    while (sb.size() != 0) begin
      idle_cycle();
      n++;
      if (n > 400) begin
        tests++;
        fails++;
        $display("FAIL scoreboard_drain: got %0d events outstanding, required 0", sb.size());
        sb.delete();
      end
    end
    idle_cycle();
  endtask

  task automatic ssi_handshake();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (start_stream_in) break;
      n++;
      if (n > 300) begin
        tests++;
        fails++;
        $display("FAIL ssi_timeout: got start_stream_in=0, required 1");
        break;
      end
    end
    repeat (4) idle_cycle();
    ready_stream_in = 1'b1;
    idle_cycle();
    ready_stream_in = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_s_tready"}, PW'(s_tready), '0);
    chk({tag, "_start_loader"}, PW'(start_loader), '0);
    chk({tag, "_wr_data"}, wr_data, '0);
    chk({tag, "_num_cfg"}, PW'(num_entry_config_table), '0);
    chk({tag, "_num_inb"}, PW'(num_entry_inbound), '0);
    chk({tag, "_start_stream_in"}, PW'(start_stream_in), '0);
    chk({tag, "_busy"}, PW'(busy), '0);
    chk({tag, "_err"}, PW'(err), '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish after 50000 cycles, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst             = 1'b0;
    s_tdata         = '0;
    s_tvalid        = 1'b0;
    s_tlast         = 1'b0;
    ready_stream_in = 1'b0;
    #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    repeat (2) idle_cycle();

    // Nominal FIR load, ready handshake arrives late.
    expect_ev(EV_TL, 0, -1);
    expect_load(30, 1'b0);
    send_pkt(8'hC0, 8'd2, 8'd16, 30, 1'b0);
    chk("hdr_num_cfg", PW'(num_entry_config_table), PW'(2));
    chk("hdr_num_inb", PW'(num_entry_inbound), PW'(16));
    ssi_handshake();
    wait_sb();

    // Gapped upstream, ready already high.
    ready_stream_in = 1'b1;
    expect_ev(EV_TL, 0, -1);
    expect_load(30, 1'b1);
    send_pkt(8'hC0, 8'd2, 8'd16, 30, 1'b1);
    wait_sb();
    ready_stream_in = 1'b0;

    // Wrong opcode: discarded, counts keep previous values.
    expect_ev(EV_ERR, 0, -1);
    expect_ev(EV_TL, 0, -1);
    expect_ev(EV_BF, 0, 1);
    send_pkt(8'hA5, 8'd3, 8'd3, 4, 1'b0);
    wait_sb();
    chk("badop_busy", PW'(busy), '0);
    chk("badop_num_cfg_held", PW'(num_entry_config_table), PW'(2));

    // Oversized body (72 > 64).
    expect_ev(EV_ERR, 0, -1);
    expect_ev(EV_TL, 0, -1);
    expect_ev(EV_BF, 0, 1);
    send_pkt(8'hC0, 8'd8, 8'd16, 3, 1'b0);
    wait_sb();
    chk("big_num_inb_held", PW'(num_entry_inbound), PW'(16));

    // Early s_tlast on beat 10 of a 30-phit body.
    expect_ev(EV_TL, 0, -1);
    expect_ev(EV_ERR, 0, 1);
    expect_ev(EV_BF, 0, 0);
    send_pkt(8'hC0, 8'd2, 8'd16, 10, 1'b0);
    wait_sb();

    // 32-beat body for total 30: one err, then normal launch from phit 1.
    ready_stream_in = 1'b1;
    expect_ev(EV_ERR, 0, -1);
    expect_ev(EV_TL, 0, 1);
    expect_load(30, 1'b1);
    send_pkt(8'hC0, 8'd2, 8'd16, 32, 1'b0);
    wait_sb();
    ready_stream_in = 1'b0;

    // Reset in the middle of the drain burst.
    expect_ev(EV_TL, 0, -1);
    expect_ev(EV_SL, 0, 1);
    expect_ev(EV_WR, 1, 3);
    for (int k = 2; k <= 12; k++) expect_ev(EV_WR, k, 1);
    expect_ev(EV_BF, 0, -1);
    send_pkt(8'hC0, 8'd2, 8'd16, 30, 1'b0);
    n = 0;
    forever begin
      @(negedge clk);
      if (wr_data == PW'(12)) break;
      n++;
      if (n > 200) begin
        tests++;
        fails++;
        $display("FAIL phit12_timeout: got no wr_data=c, required c");
        break;
      end
    end
    #1;
    rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    idle_cycle();
    idle_cycle();
    rst = 1'b0;
    repeat (2) idle_cycle();
    wait_sb();

    // Post-reset nominal packet.
    ready_stream_in = 1'b1;
    expect_ev(EV_TL, 0, -1);
    expect_load(30, 1'b1);
    send_pkt(8'hC0, 8'd2, 8'd16, 30, 1'b0);
    wait_sb();
    ready_stream_in = 1'b0;
    chk("final_busy", PW'(busy), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
